dq_bank_reader: RTL and testbench

Read-side companion to the DQ latch storage: holds a bank of `DEPTH` words of `WIDTH` bits, written word-at-a-time with an enable, and streams a contiguous address range out through a valid/ready handshake. A single `rd_start` command triggers the stream, and the engine handles addressing, wrap-around and back-pressure. It sits between the bitcell storage and any consumer that drains stored words serially, such as a display, a checker or a bus bridge.

---
 rtl/dq_pkg.sv | 6 +
 rtl/dq_word_bank.sv | 29 ++
 rtl/dq_bank_reader.sv | 89 ++++++++
 tb/tb_dq_bank_reader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dq_pkg.sv
// dq_pkg: shared FSM state type and default geometry for the DQ bank reader.
package dq_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    localparam int DQ_WIDTH = 4;
    localparam int DQ_DEPTH = 16;
endpackage

// File: rtl/dq_word_bank.sv
// dq_word_bank: word storage with async clear, clocked write port and combinational read mux.
module dq_word_bank
    import dq_pkg::*;
#(
    parameter int WIDTH = DQ_WIDTH,
    parameter int DEPTH = DQ_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read is taken before the edge, so a same-cycle write is seen only by later fetches.
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/dq_bank_reader.sv
// dq_bank_reader: streams a contiguous, wrapping address range of the word bank
// through a valid/ready port after a single rd_start command.
module dq_bank_reader
    import dq_pkg::*;
#(
    parameter int WIDTH = DQ_WIDTH,
    parameter int DEPTH = DQ_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_start,
    input  logic [AW-1:0]    rd_addr,
    input  logic [AW:0]      rd_len,
    output logic             rd_busy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rd_done
);
    state_t           state;
    logic [AW-1:0]    cur_addr;
    logic [AW:0]      remaining;
    logic [AW-1:0]    fetch_addr;
    logic [WIDTH-1:0] fetch_data;
    logic             hs;

    dq_word_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (fetch_addr),
        .rd_data (fetch_data)
    );

    // cur_addr tracks the word currently presented; the next fetch is one past it.
    assign fetch_addr = (state == IDLE) ? rd_addr : cur_addr + 1'b1;
    assign hs = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            rd_busy   <= 1'b0;
            rd_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rd_start) begin
                    if (rd_len != '0) begin
                        cur_addr  <= rd_addr;
                        remaining <= rd_len;
                        out_data  <= fetch_data;
                        out_valid <= 1'b1;
                        rd_busy   <= 1'b1;
                        state     <= STREAM;
                    end else begin
                        rd_done <= 1'b1;
                        state   <= DONE;
                    end
                end
                STREAM: if (hs) begin
                    if (remaining == (AW+1)'(1)) begin
                        out_valid <= 1'b0;
                        rd_busy   <= 1'b0;
                        rd_done   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cur_addr  <= fetch_addr;
                        out_data  <= fetch_data;
                        remaining <= remaining - 1'b1;
                    end
                end
                DONE: begin
                    rd_done <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dq_bank_reader.sv
// tb_dq_bank_reader: scoreboard bench; expected words are queued at rd_start and
// popped on every observed handshake.
module tb_dq_bank_reader;
    logic       clk = 0;
    logic       rst = 1;
    logic       wr_en = 0;
    logic [3:0] wr_addr = 0;
    logic [3:0] wr_data = 0;
    logic       rd_start = 0;
    logic [3:0] rd_addr = 0;
    logic [4:0] rd_len = 0;
    logic       rd_busy;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1;
    logic       rd_done;

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [3:0] m [16];
    logic [3:0] exp_q [$];
    logic       stall_prev = 0;
    logic [3:0] held = 0;

    dq_bank_reader dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_start  (rd_start),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .rd_busy   (rd_busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_done   (rd_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 unit after posedge; outputs are observed on negedge.
    always @(negedge clk) begin
        if (rd_done) done_cnt++;
        if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, held);
        end
        stall_prev = out_valid && !out_ready && !rst;
        held = out_data;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_word", 1, 0);
            else check("word", out_data, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        wr_en = 1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 0;
        m[a] = d;
    endtask

    task automatic start(input logic [3:0] a, input logic [4:0] len, input bit push);
        logic [3:0] x;
        if (push) for (int i = 0; i < len; i++) begin
            x = a + 4'(i);
            exp_q.push_back(m[x]);
        end
        rd_start = 1;
        rd_addr = a;
        rd_len = len;
        step();
        rd_start = 0;
    endtask

    task automatic wait_done(input bit tog, input int exp_done);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rd_done;
            @(posedge clk);
            #1;
            if (tog) out_ready = ~out_ready;
        end
        out_ready = 1;
        check("done_seen", seen, 1);
        check("queue_empty", exp_q.size(), 0);
        check("busy_after", rd_busy, 0);
        check("valid_after", out_valid, 0);
        step();
        check("done_cnt", done_cnt, exp_done);
        check("done_low", rd_done, 0);
    endtask

    initial begin
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", rd_busy, 0);
        check("rst_done", rd_done, 0);
        check("rst_data", out_data, 0);
        for (int i = 0; i < 16; i++) m[i] = 0;
        @(negedge clk);
        rst = 0;
        step();
        for (int i = 0; i < 16; i++) wr(4'(i), 4'(i));

        start(0, 16, 1);
        check("busy_start", rd_busy, 1);
        check("valid_start", out_valid, 1);
        wait_done(0, 1);

        start(14, 4, 1);
        wait_done(0, 2);

        out_ready = 1;
        start(3, 3, 1);
        wait_done(1, 3);

        start(0, 0, 0);
        check("zero_done", rd_done, 1);
        check("zero_valid", out_valid, 0);
        check("zero_busy", rd_busy, 0);
        wait_done(0, 4);

        start(0, 5, 1);
        step();
        start(9, 3, 0);
        wait_done(0, 5);

        // Word 2 is fetched in the same edge it is overwritten; word 4 is fetched after.
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(4'hA); exp_q.push_back(5); exp_q.push_back(6); exp_q.push_back(7);
        start(0, 8, 0);
        step();
        wr(2, 4'hA);
        wr(4, 4'hA);
        wait_done(0, 6);

        start(0, 8, 1);
        step();
        step();
        check("pre_rst_data", out_data, m[2]);
        #2 rst = 1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", rd_busy, 0);
        check("arst_done", rd_done, 0);
        check("arst_data", out_data, 0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) m[i] = 0;
        @(negedge clk);
        rst = 0;
        step();
        check("no_done_abort", done_cnt, 6);
        start(0, 16, 1);
        wait_done(0, 7);

        wr(5, 4'h7);
        wr(6, 4'hC);
        wr(7, 4'h3);
        start(5, 3, 1);
        wait_done(0, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
